// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: upstream feeder for the 1-bit systolic matrix multiplier.
// Latches one (A, B) job via valid/ready, drives the diagonally skewed lane
// vectors for N feed steps, holds the lanes at zero for DRAIN_CYC cycles, then
// pulses done. Optional macro SKEW_FEEDER_JOB_COUNT_EN adds a 16-bit job_count.
module systolic_skew_feeder #(
  parameter int N         = 3,
  parameter int DW        = 1,
  parameter int DRAIN_CYC = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [N*N*DW-1:0]         a_mat,
  input  logic [N*N*DW-1:0]         b_mat,
  input  logic                      abort,
`ifdef SKEW_FEEDER_JOB_COUNT_EN
  output logic [15:0]               job_count,
`endif
  output logic [(2*N-1)*DW-1:0]     ai_lane,
  output logic [(2*N-1)*DW-1:0]     bi_lane,
  output logic                      feed_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int L   = 2*N - 1;
  localparam int LW  = L*DW;
  localparam int MW  = N*N*DW;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [SW-1:0]  STEP_LAST  = SW'(N-1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  logic [SW-1:0]   step_r;
  logic [DCW-1:0]  drain_r;
  logic [MW-1:0]   a_r;
  logic [MW-1:0]   b_r;
  logic [LW-1:0]   ai_lane_r;
  logic [LW-1:0]   bi_lane_r;
  logic            feed_valid_r;
  logic            busy_r;
  logic            done_r;
  logic            load_ready_r;
  logic            done_set_s;

  // Left edge, step k: lane (k+c) carries A(k,c); every other lane is zero.
  function automatic logic [LW-1:0] skew_a(input logic [MW-1:0] mat, input int k);
    logic [LW-1:0] lanes;
    lanes = {LW{1'b0}};
    for (int c = 0; c < N; c++) begin
      lanes[(k+c)*DW +: DW] = mat[(k*N+c)*DW +: DW];
    end
    return lanes;
  endfunction

  // Top edge, step k: lane (k+c) carries B(c,k); every other lane is zero.
  function automatic logic [LW-1:0] skew_b(input logic [MW-1:0] mat, input int k);
    logic [LW-1:0] lanes;
    lanes = {LW{1'b0}};
    for (int c = 0; c < N; c++) begin
      lanes[(k+c)*DW +: DW] = mat[(c*N+k)*DW +: DW];
    end
    return lanes;
  endfunction

  // Last drain cycle completing without an abort: the job finishes at this edge.
  assign done_set_s = (state_r == DRAIN) && !abort && (drain_r == DRAIN_LAST);

  // Job sequencer: accept, feed N skewed steps, drain, pulse done; abort cancels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      step_r       <= {SW{1'b0}};
      drain_r      <= {DCW{1'b0}};
      a_r          <= {MW{1'b0}};
      b_r          <= {MW{1'b0}};
      ai_lane_r    <= {LW{1'b0}};
      bi_lane_r    <= {LW{1'b0}};
      feed_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid && load_ready_r) begin
            a_r          <= a_mat;
            b_r          <= b_mat;
            step_r       <= {SW{1'b0}};
            ai_lane_r    <= skew_a(a_mat, 0);
            bi_lane_r    <= skew_b(b_mat, 0);
            feed_valid_r <= 1'b1;
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
            state_r      <= FEED;
          end else begin
            load_ready_r <= 1'b1;
          end
        end
        FEED: begin
          if (abort) begin
            state_r      <= IDLE;
            step_r       <= {SW{1'b0}};
            ai_lane_r    <= {LW{1'b0}};
            bi_lane_r    <= {LW{1'b0}};
            feed_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
          end else if (step_r == STEP_LAST) begin
            state_r      <= DRAIN;
            drain_r      <= {DCW{1'b0}};
            ai_lane_r    <= {LW{1'b0}};
            bi_lane_r    <= {LW{1'b0}};
            feed_valid_r <= 1'b0;
          end else begin
            step_r       <= step_r + SW'(1);
            ai_lane_r    <= skew_a(a_r, int'(step_r) + 1);
            bi_lane_r    <= skew_b(b_r, int'(step_r) + 1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state_r      <= IDLE;
            drain_r      <= {DCW{1'b0}};
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
          end else if (done_set_s) begin
            state_r      <= IDLE;
            drain_r      <= {DCW{1'b0}};
            done_r       <= 1'b1;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
          end else begin
            drain_r      <= drain_r + DCW'(1);
          end
        end
        default: begin
          state_r      <= IDLE;
          step_r       <= {SW{1'b0}};
          drain_r      <= {DCW{1'b0}};
          ai_lane_r    <= {LW{1'b0}};
          bi_lane_r    <= {LW{1'b0}};
          feed_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          load_ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef SKEW_FEEDER_JOB_COUNT_EN
  logic [15:0] job_count_r;

  // Count completed jobs; aborted jobs never reach done_set_s. Wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_count_r <= 16'd0;
    end else if (done_set_s) begin
      job_count_r <= job_count_r + 16'd1;
    end else begin
      job_count_r <= job_count_r;
    end
  end

  assign job_count = job_count_r;
`endif

  assign load_ready = load_ready_r;
  assign ai_lane    = ai_lane_r;
  assign bi_lane    = bi_lane_r;
  assign feed_valid = feed_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed cases from the test
// plan plus randomized jobs, all checked against a job-timeline reference model.
module tb_systolic_skew_feeder;

  localparam int N         = 3;
  localparam int DW        = 1;
  localparam int DRAIN_CYC = 6;
  localparam int L         = 2*N - 1;
  localparam int LW        = L*DW;
  localparam int MW        = N*N*DW;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [MW-1:0] a_mat;
  logic [MW-1:0] b_mat;
  logic          abort;
  logic [LW-1:0] ai_lane;
  logic [LW-1:0] bi_lane;
  logic          feed_valid;
  logic          busy;
  logic          done;
`ifdef SKEW_FEEDER_JOB_COUNT_EN
  logic [15:0]   job_count;
  int            exp_jobs;
`endif

  int checks;
  int errors;

  // Reference model: a job is a timeline of edges since acceptance.
  bit            m_active;
  int            m_t;
  logic [MW-1:0] m_a;
  logic [MW-1:0] m_b;
  bit            m_done;

  systolic_skew_feeder #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .abort      (abort),
`ifdef SKEW_FEEDER_JOB_COUNT_EN
    .job_count  (job_count),
`endif
    .ai_lane    (ai_lane),
    .bi_lane    (bi_lane),
    .feed_valid (feed_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected lane vector: lane j holds element c = j-k of row k (A) or column k (B).
  function automatic logic [LW-1:0] exp_lanes(input logic [MW-1:0] m, input int k, input bit is_b);
    logic [LW-1:0] v;
    v = '0;
    for (int j = 0; j < L; j++) begin
      int c;
      c = j - k;
      if (c >= 0 && c < N) begin
        if (is_b) v[j*DW +: DW] = m[(c*N+k)*DW +: DW];
        else      v[j*DW +: DW] = m[(k*N+c)*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_done   = 1'b0;
`ifdef SKEW_FEEDER_JOB_COUNT_EN
    exp_jobs = 0;
`endif
  endtask

  task automatic model_edge(input bit lv, input bit ab, input logic [MW-1:0] a, input logic [MW-1:0] b);
    m_done = 1'b0;
    if (!m_active) begin
      if (lv) begin
        m_active = 1'b1;
        m_t      = 1;
        m_a      = a;
        m_b      = b;
      end
    end else if (ab) begin
      m_active = 1'b0;
    end else if (m_t == N + DRAIN_CYC) begin
      m_active = 1'b0;
      m_done   = 1'b1;
`ifdef SKEW_FEEDER_JOB_COUNT_EN
      exp_jobs = (exp_jobs + 1) % 65536;
`endif
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_all();
    bit feeding;
    feeding = m_active && (m_t <= N);
    check_eq("load_ready", load_ready, !m_active);
    check_eq("busy",       busy,       m_active);
    check_eq("done",       done,       m_done);
    check_eq("feed_valid", feed_valid, feeding);
    check_eq("ai_lane",    ai_lane,    feeding ? exp_lanes(m_a, m_t-1, 1'b0) : '0);
    check_eq("bi_lane",    bi_lane,    feeding ? exp_lanes(m_b, m_t-1, 1'b1) : '0);
`ifdef SKEW_FEEDER_JOB_COUNT_EN
    check_eq("job_count",  job_count,  exp_jobs[15:0]);
`endif
  endtask

  task automatic step(input bit lv, input bit ab, input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    load_valid = lv;
    abort      = ab;
    a_mat      = a;
    b_mat      = b;
    @(posedge clk);
    model_edge(lv, ab, a, b);
    #1;
    compare_all();
  endtask

  function automatic logic [MW-1:0] rnd_mat();
    return MW'($urandom);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    model_reset();

    // Reset held with a pending job: nothing is accepted.
    rst_n      = 1'b0;
    load_valid = 1'b1;
    abort      = 1'b0;
    a_mat      = rnd_mat();
    b_mat      = rnd_mat();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_load_ready", load_ready, 1'b1);
    check_eq("rst_ai", ai_lane, '0);
    check_eq("rst_bi", bi_lane, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_feed_valid", feed_valid, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    rst_n      = 1'b1;
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());

    // Directed identity example from the plan.
    step(1'b1, 1'b0, 9'b100010001, 9'b001010100);
    check_eq("dir_s0_ai", ai_lane, 5'b00001);
    check_eq("dir_s0_bi", bi_lane, 5'b00100);
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_s1_ai", ai_lane, 5'b00100);
    check_eq("dir_s1_bi", bi_lane, 5'b00100);
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_s2_ai", ai_lane, 5'b10000);
    check_eq("dir_s2_bi", bi_lane, 5'b00100);
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_drain_lanes", {ai_lane, bi_lane}, '0);
    check_eq("dir_drain_fv", feed_valid, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_no_done_early", done, 1'b0);
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_done_e9", done, 1'b1);
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    check_eq("dir_done_one_cycle", done, 1'b0);

    // Back-to-back: load_valid held, second accept in the done cycle.
    for (int i = 0; i < N + DRAIN_CYC; i++) step(1'b1, 1'b0, rnd_mat(), rnd_mat());
    step(1'b1, 1'b0, rnd_mat(), rnd_mat());
    check_eq("b2b_done", done, 1'b1);
    step(1'b1, 1'b0, rnd_mat(), rnd_mat());
    check_eq("b2b_second_feed", feed_valid, 1'b1);
    check_eq("b2b_done_drop", done, 1'b0);
    for (int i = 0; i < N + DRAIN_CYC + 2; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());

    // Abort in the second drain cycle.
    step(1'b1, 1'b0, rnd_mat(), rnd_mat());
    for (int i = 0; i < N + 1; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    step(1'b0, 1'b1, rnd_mat(), rnd_mat());
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ready", load_ready, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());

    // Abort together with load_valid in IDLE: job is accepted.
    step(1'b1, 1'b1, rnd_mat(), rnd_mat());
    check_eq("idle_abort_accept", busy, 1'b1);
    for (int i = 0; i < N + DRAIN_CYC + 1; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());

    // Reset mid-FEED after step 1.
    step(1'b1, 1'b0, rnd_mat(), rnd_mat());
    step(1'b0, 1'b0, rnd_mat(), rnd_mat());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_lanes", {ai_lane, bi_lane}, '0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_fv", feed_valid, 1'b0);
    check_eq("mid_rst_ready", load_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, rnd_mat(), rnd_mat());

    // Randomized traffic with changing matrices and occasional aborts.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd_mat(), rnd_mat());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
